// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receiver.
package uart_rx_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Clock cycles per bit time.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO. Pointers carry one extra wrap bit so that
// full and empty are told apart without a separate count.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int WIDTH = UART_DATA_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push_en;
    logic             pop_en;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A pop on an empty FIFO is ignored; a push on a full FIFO only lands
    // when the head is leaving in the same cycle.
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);

    // Head byte is forced to zero while empty so the output reads 0 after reset.
    assign rdata = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    // Next pointer and storage values.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        mem_d  = mem_q;
        if (push_en) begin
            mem_d[wptr_q[AW-1:0]] = wdata;
            wptr_d = wptr_q + (AW+1)'(1);
        end
        if (pop_en) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    // Pointer and storage registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/uart_rx_io.sv
// 8N1 UART receiver: line synchronizer, deframing FSM, sticky error flags
// and a small show-ahead receive FIFO drained by the CPU.
//
// state | meaning
// IDLE  | line idle, waiting for a low level on rx_s
// START | timing to mid start bit, rejecting glitches
// DATA  | sampling 8 data bits LSB-first at mid bit
// STOP  | sampling the stop bit, then push or flag a frame error
module uart_rx_io
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 10000000,
    parameter int BAUD_RATE   = 1000000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   i_uart_rx,
    input  logic                   i_pop,
    input  logic                   i_clr_err,
    output logic [UART_DATA_W-1:0] o_data,
    output logic                   o_valid,
    output logic                   o_frame_err,
    output logic                   o_overrun
);

    localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int TW  = (DIV >= 4) ? $clog2(DIV) : 2;
    localparam logic [TW-1:0] FULL_LOAD = TW'(DIV - 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(DIV / 2 - 1);

    if (DIV < 4) begin : g_bad_div
        $error("uart_rx_io: CLK_FREQ_HZ / BAUD_RATE must be at least 4");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_rx_io: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    logic                   sync1_q, sync1_d;
    logic                   rx_s_q, rx_s_d;
    rx_state_t              state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   push_req;
    logic                   frame_set;
    logic                   overrun_set;
    logic                   tick;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign sync1_d = i_uart_rx;
    assign rx_s_d  = sync1_q;
    assign tick    = (timer_q == '0);

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            rx_s_q  <= rx_s_d;
        end
    end

    // Deframing FSM: next state, bit timer, bit counter and shift register.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    timer_d = HALF_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        timer_d  = FULL_LOAD;
                        bitcnt_d = '0;
                        state_d  = DATA;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d  = {rx_s_q, shift_q[UART_DATA_W-1:1]};
                    timer_d  = FULL_LOAD;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            STOP: begin
                if (tick) begin
                    // Return to IDLE immediately so a back-to-back start bit
                    // is picked up during the second half of the stop bit.
                    if (rx_s_q) begin
                        push_req = 1'b1;
                    end else begin
                        frame_set = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
        end
    end

    // A full FIFO still accepts the byte when the head pops in the same cycle.
    assign overrun_set = push_req && fifo_full && !i_pop;

    // Sticky error flags; a new error in the clearing cycle wins.
    always_comb begin
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        if (i_clr_err) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (frame_set) begin
            frame_err_d = 1'b1;
        end
        if (overrun_set) begin
            overrun_d = 1'b1;
        end
    end

    // Error flag registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_req),
        .pop    (i_pop),
        .wdata  (shift_q),
        .rdata  (o_data),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign o_valid     = !fifo_empty;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_io.sv
// Bench for uart_rx_io at default parameters (DIV = 10). Inputs change on
// the falling clock edge and outputs are sampled on the falling edge.
module tb_uart_rx_io;

    localparam int DIV = 10;

    logic       clk;
    logic       resetn;
    logic       i_uart_rx;
    logic       i_pop;
    logic       i_clr_err;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;

    int         n_checks;
    int         n_errors;
    logic [7:0] exp_q [$];

    uart_rx_io dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_uart_rx   (i_uart_rx),
        .i_pop       (i_pop),
        .i_clr_err   (i_clr_err),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one 8N1 character starting at the current falling edge and
    // returns on the falling edge that ends the stop bit. With pop_at_push
    // the head is popped in the cycle this character is pushed.
    task automatic send_byte(input logic [7:0] b, input logic stop_val, input bit pop_at_push);
        logic [7:0] exp;
        i_uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            i_uart_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        i_uart_rx = stop_val;
        repeat (DIV - 3) @(negedge clk);
        if (pop_at_push) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++;
            if (o_valid !== 1'b1 || o_data !== exp) begin
                n_errors++;
                $display("FAIL pop_at_push_head: got valid=%b data=%h, want valid=1 data=%h", o_valid, o_data, exp);
            end
            i_pop = 1'b1;
        end
        @(negedge clk);
        i_pop = 1'b0;
        repeat (2) @(negedge clk);
        i_uart_rx = 1'b1;
    endtask

    // Pops every expected byte, comparing head and valid, then checks empty.
    task automatic drain(input string name);
        logic [7:0] exp;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            n_checks++;
            if (o_valid !== 1'b1 || o_data !== exp) begin
                n_errors++;
                $display("FAIL %s_data: got valid=%b data=%h, want valid=1 data=%h", name, o_valid, o_data, exp);
            end
            i_pop = 1'b1;
            @(negedge clk);
            i_pop = 1'b0;
        end
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_empty: got valid=%b, want 0", name, o_valid);
        end
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        i_uart_rx = 1'b1;
        i_pop     = 1'b0;
        i_clr_err = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (o_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b, want 0", o_valid); end
        n_checks++;
        if (o_data !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h, want 00", o_data); end
        n_checks++;
        if (o_frame_err !== 1'b0) begin n_errors++; $display("FAIL reset_frame_err: got %b, want 0", o_frame_err); end
        n_checks++;
        if (o_overrun !== 1'b0) begin n_errors++; $display("FAIL reset_overrun: got %b, want 0", o_overrun); end
        resetn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_byte();
        exp_q.push_back(8'h55);
        fork
            send_byte(8'h55, 1'b1, 1'b0);
            begin
                repeat (97) @(negedge clk);
                n_checks++;
                if (o_valid !== 1'b0) begin n_errors++; $display("FAIL single_valid_early: got %b at cycle 97, want 0", o_valid); end
                @(negedge clk);
                n_checks++;
                if (o_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid_rise: got %b at cycle 98, want 1", o_valid); end
            end
        join
        n_checks++;
        if (o_frame_err !== 1'b0 || o_overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL single_flags: got frame_err=%b overrun=%b, want 0 0", o_frame_err, o_overrun);
        end
        drain("single");
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        bytes[0] = 8'hA3;
        bytes[1] = 8'h0F;
        bytes[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(bytes[i]);
            send_byte(bytes[i], 1'b1, 1'b0);
        end
        repeat (2) @(negedge clk);
        drain("b2b");
        n_checks++;
        if (o_frame_err !== 1'b0 || o_overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_flags: got frame_err=%b overrun=%b, want 0 0", o_frame_err, o_overrun);
        end
    endtask

    task automatic test_glitch();
        i_uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        i_uart_rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        n_checks++;
        if (o_valid !== 1'b0) begin n_errors++; $display("FAIL glitch_valid: got %b, want 0", o_valid); end
        n_checks++;
        if (o_frame_err !== 1'b0 || o_overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL glitch_flags: got frame_err=%b overrun=%b, want 0 0", o_frame_err, o_overrun);
        end
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        drain("after_glitch");
    endtask

    task automatic test_frame_err();
        fork
            send_byte(8'h3C, 1'b0, 1'b0);
            begin
                repeat (97) @(negedge clk);
                n_checks++;
                if (o_frame_err !== 1'b0) begin n_errors++; $display("FAIL frame_err_early: got %b at cycle 97, want 0", o_frame_err); end
                @(negedge clk);
                n_checks++;
                if (o_frame_err !== 1'b1) begin n_errors++; $display("FAIL frame_err_set: got %b at cycle 98, want 1", o_frame_err); end
            end
        join
        repeat (2 * DIV) @(negedge clk);
        n_checks++;
        if (o_valid !== 1'b0) begin n_errors++; $display("FAIL frame_fifo_empty: got valid=%b, want 0", o_valid); end
        n_checks++;
        if (o_frame_err !== 1'b1) begin n_errors++; $display("FAIL frame_err_sticky: got %b, want 1", o_frame_err); end
        i_clr_err = 1'b1;
        @(negedge clk);
        i_clr_err = 1'b0;
        n_checks++;
        if (o_frame_err !== 1'b0) begin n_errors++; $display("FAIL frame_err_clear: got %b, want 0", o_frame_err); end
    endtask

    task automatic test_overrun();
        logic [7:0] b;
        for (int i = 1; i <= 5; i++) begin
            b = 8'(i);
            if (i <= 4) exp_q.push_back(b);
            send_byte(b, 1'b1, 1'b0);
        end
        n_checks++;
        if (o_overrun !== 1'b1) begin n_errors++; $display("FAIL overrun_set: got %b, want 1", o_overrun); end
        n_checks++;
        if (o_frame_err !== 1'b0) begin n_errors++; $display("FAIL overrun_frame_err: got %b, want 0", o_frame_err); end
        drain("overrun");
        i_clr_err = 1'b1;
        @(negedge clk);
        i_clr_err = 1'b0;
        n_checks++;
        if (o_overrun !== 1'b0) begin n_errors++; $display("FAIL overrun_clear: got %b, want 0", o_overrun); end

        for (int i = 1; i <= 4; i++) begin
            b = 8'(i);
            exp_q.push_back(b);
            send_byte(b, 1'b1, 1'b0);
        end
        send_byte(8'h05, 1'b1, 1'b1);
        exp_q.push_back(8'h05);
        n_checks++;
        if (o_overrun !== 1'b0) begin n_errors++; $display("FAIL pop_push_full_overrun: got %b, want 0", o_overrun); end
        drain("pop_push_full");
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'h81;
        exp_q.push_back(8'h22);
        send_byte(8'h22, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        repeat (2 * DIV) @(negedge clk);
        n_checks++;
        if (o_valid !== 1'b1 || o_frame_err !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_setup: got valid=%b frame_err=%b, want 1 1", o_valid, o_frame_err);
        end
        i_uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            i_uart_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        i_uart_rx = b[4];
        repeat (DIV / 2) @(negedge clk);
        resetn = 1'b0;
        #1;
        n_checks++;
        if (o_valid !== 1'b0 || o_data !== 8'h00 || o_frame_err !== 1'b0 || o_overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_outputs: got valid=%b data=%h frame_err=%b overrun=%b, want all 0",
                     o_valid, o_data, o_frame_err, o_overrun);
        end
        exp_q.delete();
        i_uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.push_back(8'h7E);
        send_byte(8'h7E, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        drain("after_reset");
        n_checks++;
        if (o_frame_err !== 1'b0 || o_overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL after_reset_flags: got frame_err=%b overrun=%b, want 0 0", o_frame_err, o_overrun);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        resetn    = 1'b0;
        i_uart_rx = 1'b1;
        i_pop     = 1'b0;
        i_clr_err = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_io.md
# uart_rx_io

UART receiver with a small receive FIFO, the receive counterpart of the SoC's UART transmitter. It samples the `UART_RX` pin, deframes 8N1 characters at a fixed baud rate and queues the bytes. The CPU drains the queue through the IO memory map, using the same IO read-data path that already carries the transmitter's busy bit.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 10000000, system clock frequency in Hz.
- `BAUD_RATE`, 1000000, line rate in bit/s.
  - `DIV = CLK_FREQ_HZ / BAUD_RATE` (integer division).
  - `DIV` ≥ 4 is required; elaboration fails otherwise.
- `FIFO_DEPTH`, 4, receive FIFO entries. Must be a power of 2 and ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous active-low reset.
- `i_uart_rx`  in  1  serial line. Asynchronous to `clk`; idles high.
- `i_pop`  in  1  consume the head byte. Ignored when `o_valid`=0.
- `i_clr_err`  in  1  clear both sticky error flags.
- `o_data`  out  8  head byte of the FIFO (show-ahead). Value is don't-care when `o_valid`=0.
- `o_valid`  out  1  FIFO non-empty.
- `o_frame_err`  out  1  sticky: a character's stop bit was sampled low.
- `o_overrun`  out  1  sticky: a good character was received while the FIFO was full.

## Operation
- **Input synchronizer:** `i_uart_rx` passes through a 2-flop synchronizer that resets to 1, producing `rx_s`.
- **State machine** (`IDLE`, `START`, `DATA`, `STOP`). A single bit-timer counts down; `bitcnt` is 3 bits.
  - `IDLE`: when `rx_s`=0, load timer = `DIV/2 − 1` and go to `START`.
  - `START`: when the timer reaches 0, sample `rx_s`.
    - If 1 (glitch), return to `IDLE`.
    - If 0, load timer = `DIV − 1`, set `bitcnt`=0 and go to `DATA`.
  - `DATA`: when the timer reaches 0, shift `rx_s` into the shift register LSB-first and reload timer = `DIV − 1`.
    - After bit 7, go to `STOP`.
  - `STOP`: when the timer reaches 0, sample `rx_s`.
    - If 1, push the byte.
    - If 0, set `o_frame_err` and discard the byte.
    - In both cases go to `IDLE` in the same cycle, so a back-to-back start bit is caught within half a bit time.
- **Push:** if the FIFO is full and there is no pop in the same cycle, drop the byte and set `o_overrun`. The FIFO contents are unchanged.
- **Simultaneous push and pop when full:** both take effect and no overrun is flagged.
- **Simultaneous push and pop when empty:** the pop is ignored and the push takes effect.
- **`i_clr_err`:** clears both flags. If clearing coincides with a new error event, the set wins.
- **Reset:** asserting reset mid-character immediately returns to `IDLE`. The FIFO is emptied, flags are cleared and the synchronizer is forced to 1.

## Timing
- Output reset values: `o_valid`=0, `o_frame_err`=0, `o_overrun`=0, `o_data`=8'h00.
- Cycle 0 is the first cycle in which `rx_s`=0 is seen in `IDLE`. This is 2 cycles after the pin falls, for an edge aligned to `clk`.
  - Start bit is sampled at cycle `DIV/2`.
  - Data bit k is sampled at cycle `DIV/2 + (k+1)·DIV`.
  - Stop bit is sampled at cycle `DIV/2 + 9·DIV`.
  - With the default `DIV`=10: start at 5, bit 0 at 15, stop at 95.
- `o_valid` and `o_data` update on the clock edge after the stop sample. With the default parameters `o_valid` rises 98 cycles after the pin edge.
- A pop takes effect at the edge it is sampled on: the next head byte, or `o_valid`=0, is visible in the following cycle.
- The error flags set on the edge after the offending sample.
- Sustained throughput is one byte per `10·DIV` cycles. No bytes are lost if the consumer pops at least once per character time.

## Structure
- Package `uart_rx_pkg`:
  - state enum `rx_state_t` with the four states above;
  - function `calc_div(clk_hz, baud)`;
  - constant `UART_DATA_W = 8`.
- Sub-module `uart_rx_fifo`:
  - synchronous show-ahead FIFO, parameterised on width and depth;
  - pointers one bit wider than the address, for full/empty detection;
  - ports `push`, `pop`, `wdata`, `rdata`, `full`, `empty`.
- The top level holds the synchronizer, the FSM, the shift register and the sticky flags.

## Test plan
- **Single byte:** drive 0x55 at 1 Mbaud, default parameters → `o_valid` rises 98 cycles after the falling edge, `o_data`=0x55, both flags stay 0.
- **Back-to-back:** send 0xA3, 0x0F, 0xFF with no idle gap, then pop 3 times → the bytes come out in order and `o_valid`=0 after the third pop.
- **Glitch:** a low pulse of 3 cycles on the line → the FSM returns to `IDLE`, `o_valid` stays 0, no flags set.
- **Frame error:** send 0x3C with the stop bit driven low → `o_frame_err`=1 and the FIFO stays empty. Pulse `i_clr_err` → the flag reads 0 next cycle.
- **Overrun:** send 5 bytes 0x01..0x05 with no pops (`FIFO_DEPTH`=4) → `o_overrun`=1 and the FIFO holds 0x01..0x04.
  - Repeat with a pop asserted in the cycle the fifth byte is pushed → no overrun, 0x05 is queued.
- **Reset mid-character:** assert `resetn`=0 during data bit 4 of 0x81 → all outputs go to 0 at once. After release, a fresh 0x7E is received correctly.
